// File: rtl/huffman_seq_pkg.sv
// Shared types, constants and helpers for the Huffman job sequencer.
package huffman_seq_pkg;
  localparam int NUM_CSR   = 4;
  localparam int CSR_W_DEF = 11;
  localparam int LEN_W_DEF = 32;

  typedef enum logic [2:0] {IDLE, CSR, SETTLE, REQ, START, RUN, DONE} seq_state_t;

  // LSB position of CSR field idx inside the packed job_csr bus.
  function automatic int csr_lsb(input int idx, input int csr_w);
    return idx * csr_w;
  endfunction
endpackage

// File: rtl/huffman_seq_timer.sv
// Loadable down-counter with a zero flag; used for the settle window and the run timeout.
module huffman_seq_timer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)                    count <= '0;
    else if (load)                count <= load_value;
    else if (dec && count != '0)  count <= count - W'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/huffman_job_sequencer.sv
// Job front-end for the Huffman accelerator: CSR programming, settle, request, run tracking.
// Optional build macro HUFF_SEQ_CSR_CACHE_EN skips CSR writes whose value is already loaded.
module huffman_job_sequencer
  import huffman_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CSR_W          = CSR_W_DEF,
  parameter int LEN_W          = LEN_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic                     job_encoding,
  input  logic [LEN_W-1:0]         job_head,
  input  logic [LEN_W-1:0]         job_length,
  input  logic [NUM_CSR*CSR_W-1:0] job_csr,
  output logic                     hw_csr_write,
  output logic [1:0]               hw_csr_addr,
  output logic [CSR_W-1:0]         hw_csr_data,
  output logic                     hw_encoding,
  output logic                     hw_req_valid,
  output logic [LEN_W-1:0]         hw_req_head,
  output logic [LEN_W-1:0]         hw_req_length,
  input  logic                     hw_req_ready,
  input  logic                     hw_resp_valid,
  output logic                     done_valid,
  output logic [LEN_W-1:0]         done_count,
  output logic                     done_timeout,
  output logic                     busy,
  output seq_state_t               dbg_state
);
  // job_valid/job_ready: a descriptor transfers on a cycle where both are high; ready only in IDLE.
  localparam logic [31:0] SETTLE_LOAD  = (SETTLE_CYCLES > 0)  ? 32'(SETTLE_CYCLES - 1)  : '0;
  localparam logic [31:0] TIMEOUT_LOAD = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : '0;
  localparam seq_state_t  POST_CSR     = (SETTLE_CYCLES > 0)  ? SETTLE : REQ;

  seq_state_t         state, state_n;
  logic [1:0]         idx, idx_n;
  logic [CSR_W-1:0]   csr_q [NUM_CSR];
  logic [LEN_W-1:0]   head_q, length_q, count_q;
  logic               enc_q, timeout_q;
  logic [NUM_CSR-1:0] need_in, need_q;
  logic [2:0]         pick;
  logic               tmr_load, tmr_dec, tmr_zero, hit_timeout;
  logic [31:0]        tmr_value;

  // Lowest index >= lo whose CSR still needs a write; bit 2 flags that one was found.
  function automatic logic [2:0] pick_next(input logic [NUM_CSR-1:0] need, input int lo);
    pick_next = '0;
    for (int i = NUM_CSR - 1; i >= 0; i--)
      if (need[i] && i >= lo) pick_next = {1'b1, 2'(i)};
  endfunction

`ifdef HUFF_SEQ_CSR_CACHE_EN
  logic [CSR_W-1:0]   shadow_q [NUM_CSR];
  logic [NUM_CSR-1:0] written_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      written_q <= '0;
      for (int i = 0; i < NUM_CSR; i++) shadow_q[i] <= '0;
    end else if (state == CSR) begin
      shadow_q[idx]  <= csr_q[idx];
      written_q[idx] <= 1'b1;
    end
  end

  always_comb begin
    need_in = '1;
    need_q  = '1;
    for (int i = 0; i < NUM_CSR; i++) begin
      need_in[i] = !(written_q[i] && shadow_q[i] == job_csr[csr_lsb(i, CSR_W) +: CSR_W]);
      need_q[i]  = !(written_q[i] && shadow_q[i] == csr_q[i]);
    end
  end
`else
  assign need_in = '1;
  assign need_q  = '1;
`endif

  huffman_seq_timer #(.W(32)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .zero       (tmr_zero)
  );

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    pick        = '0;
    tmr_load    = 1'b0;
    tmr_value   = SETTLE_LOAD;
    tmr_dec     = 1'b0;
    hit_timeout = 1'b0;
    case (state)
      IDLE: if (job_valid) begin
        pick = pick_next(need_in, 0);
        if (pick[2]) begin
          state_n = CSR;
          idx_n   = pick[1:0];
        end else begin
          state_n  = POST_CSR;
          tmr_load = 1'b1;
        end
      end
      CSR: begin
        pick = pick_next(need_q, int'(idx) + 1);
        if (pick[2]) idx_n = pick[1:0];
        else begin
          state_n  = POST_CSR;
          tmr_load = 1'b1;
        end
      end
      SETTLE: if (tmr_zero) state_n = REQ; else tmr_dec = 1'b1;
      REQ: if (hw_req_ready) begin
        state_n   = START;
        tmr_load  = 1'b1;
        tmr_value = TIMEOUT_LOAD;
      end
      START: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          state_n     = DONE;
          hit_timeout = 1'b1;
        end else if (!hw_req_ready) state_n = RUN;
      end
      // Completion beats a timeout expiring in the same cycle.
      RUN: begin
        tmr_dec = 1'b1;
        if (hw_req_ready) state_n = DONE;
        else if (tmr_zero) begin
          state_n     = DONE;
          hit_timeout = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      head_q    <= '0;
      length_q  <= '0;
      count_q   <= '0;
      enc_q     <= 1'b0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NUM_CSR; i++) csr_q[i] <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == IDLE && job_valid) begin
        head_q    <= job_head;
        length_q  <= job_length;
        enc_q     <= job_encoding;
        count_q   <= '0;
        timeout_q <= 1'b0;
        for (int i = 0; i < NUM_CSR; i++) csr_q[i] <= job_csr[csr_lsb(i, CSR_W) +: CSR_W];
      end
      if (state == REQ && hw_req_ready) count_q <= '0;
      if ((state == START || state == RUN) && hw_resp_valid && count_q != '1)
        count_q <= count_q + LEN_W'(1);
      if (hit_timeout) timeout_q <= 1'b1;
    end
  end

  assign job_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign hw_csr_write  = (state == CSR);
  assign hw_csr_addr   = (state == CSR) ? idx : 2'd0;
  assign hw_csr_data   = (state == CSR) ? csr_q[idx] : '0;
  assign hw_encoding   = enc_q;
  assign hw_req_valid  = (state == REQ) && hw_req_ready;
  assign hw_req_head   = head_q;
  assign hw_req_length = length_q;
  assign done_valid    = (state == DONE);
  assign done_count    = count_q;
  assign done_timeout  = timeout_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_huffman_job_sequencer.sv
// Directed bench for huffman_job_sequencer: instance a uses default timing, instance b has
// SETTLE_CYCLES=0 and TIMEOUT_CYCLES=50; a small accelerator model runs inside run_job.
module tb_huffman_job_sequencer;
  import huffman_seq_pkg::*;

  localparam int CW = 11;
  localparam int LW = 32;
`ifdef HUFF_SEQ_CSR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic            sel = 1'b0;
  logic            job_valid = 1'b0, job_encoding = 1'b0;
  logic [LW-1:0]   job_head = '0, job_length = '0;
  logic [4*CW-1:0] job_csr = '0;
  logic            hw_req_ready = 1'b1, hw_resp_valid = 1'b0;

  logic            a_job_ready, a_csr_write, a_encoding, a_req_valid, a_done_valid, a_done_timeout, a_busy;
  logic            b_job_ready, b_csr_write, b_encoding, b_req_valid, b_done_valid, b_done_timeout, b_busy;
  logic [1:0]      a_csr_addr, b_csr_addr;
  logic [CW-1:0]   a_csr_data, b_csr_data;
  logic [LW-1:0]   a_req_head, a_req_length, a_done_count, b_req_head, b_req_length, b_done_count;
  seq_state_t      a_state, b_state;

  huffman_job_sequencer u_a (
    .clock(clock), .reset(reset), .job_valid(job_valid & ~sel), .job_ready(a_job_ready),
    .job_encoding(job_encoding), .job_head(job_head), .job_length(job_length), .job_csr(job_csr),
    .hw_csr_write(a_csr_write), .hw_csr_addr(a_csr_addr), .hw_csr_data(a_csr_data),
    .hw_encoding(a_encoding), .hw_req_valid(a_req_valid), .hw_req_head(a_req_head),
    .hw_req_length(a_req_length), .hw_req_ready(hw_req_ready), .hw_resp_valid(hw_resp_valid),
    .done_valid(a_done_valid), .done_count(a_done_count), .done_timeout(a_done_timeout),
    .busy(a_busy), .dbg_state(a_state)
  );

  huffman_job_sequencer #(.SETTLE_CYCLES(0), .TIMEOUT_CYCLES(50)) u_b (
    .clock(clock), .reset(reset), .job_valid(job_valid & sel), .job_ready(b_job_ready),
    .job_encoding(job_encoding), .job_head(job_head), .job_length(job_length), .job_csr(job_csr),
    .hw_csr_write(b_csr_write), .hw_csr_addr(b_csr_addr), .hw_csr_data(b_csr_data),
    .hw_encoding(b_encoding), .hw_req_valid(b_req_valid), .hw_req_head(b_req_head),
    .hw_req_length(b_req_length), .hw_req_ready(hw_req_ready), .hw_resp_valid(hw_resp_valid),
    .done_valid(b_done_valid), .done_count(b_done_count), .done_timeout(b_done_timeout),
    .busy(b_busy), .dbg_state(b_state)
  );

  logic            job_ready, csr_write, encoding, req_valid, done_valid, done_timeout, busy;
  logic [1:0]      csr_addr;
  logic [CW-1:0]   csr_data;
  logic [LW-1:0]   req_head, req_length, done_count;
  assign job_ready    = sel ? b_job_ready    : a_job_ready;
  assign csr_write    = sel ? b_csr_write    : a_csr_write;
  assign csr_addr     = sel ? b_csr_addr     : a_csr_addr;
  assign csr_data     = sel ? b_csr_data     : a_csr_data;
  assign encoding     = sel ? b_encoding     : a_encoding;
  assign req_valid    = sel ? b_req_valid    : a_req_valid;
  assign req_head     = sel ? b_req_head     : a_req_head;
  assign req_length   = sel ? b_req_length   : a_req_length;
  assign done_valid   = sel ? b_done_valid   : a_done_valid;
  assign done_count   = sel ? b_done_count   : a_done_count;
  assign done_timeout = sel ? b_done_timeout : a_done_timeout;
  assign busy         = sel ? b_busy         : a_busy;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit              sel_b;
    bit              enc;
    logic [LW-1:0]   head;
    logic [LW-1:0]   len;
    logic [4*CW-1:0] csr;
    int              n_resp;
    bit              hang;
    bit              coincide;
    bit              poke;
    logic [3:0]      wr_mask;
    int              req_lat;
    int              done_lat;
    logic [LW-1:0]   exp_count;
    bit              exp_to;
  } vec_t;

  function automatic logic [4*CW-1:0] mk_csr(input int c0, input int c1, input int c2, input int c3);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  int            acc_cyc, req_cyc, done_cyc, req_cnt, enc_bad, head_bad;
  logic [1:0]    wr_addr[$];
  logic [CW-1:0] wr_data[$];
  int            wr_cyc[$];
  logic [LW-1:0] got_count;
  logic          got_to, got_busy;

  // Drives one job and plays the accelerator: ready drops on the cycle after the request,
  // resp_valid is high for n_resp cycles, then ready rises (same cycle as the last byte if coincide).
  task automatic run_job(input vec_t v, input int abort_k);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    req_cnt = 0; req_cyc = -1; done_cyc = -1; enc_bad = 0; head_bad = 0;
    @(posedge clock); #1;
    sel = v.sel_b; job_valid = 1'b1; job_encoding = v.enc;
    job_head = v.head; job_length = v.len; job_csr = v.csr;
    hw_req_ready = 1'b1; hw_resp_valid = 1'b0;
    @(negedge clock);
    acc_cyc = cyc;
    check("accept_ready", job_ready, 1);
    for (int i = 1; i < 3000; i++) begin
      @(posedge clock); #1;
      job_valid = v.poke && (i == 2);
      job_csr   = (i == 2) ? ~v.csr  : v.csr;
      job_head  = (i == 2) ? ~v.head : v.head;
      if (req_cyc >= 0) begin
        int k;
        k = cyc - req_cyc;
        hw_resp_valid = (k <= v.n_resp);
        if (!v.hang && ((v.coincide && k == v.n_resp) || (!v.coincide && k == v.n_resp + 1)))
          hw_req_ready = 1'b1;
        else if (k == 1)
          hw_req_ready = 1'b0;
        if (abort_k > 0 && k == abort_k) begin
          reset = 1'b1;
          break;
        end
      end
      @(negedge clock);
      if (encoding !== v.enc) enc_bad++;
      if (csr_write) begin
        wr_addr.push_back(csr_addr); wr_data.push_back(csr_data); wr_cyc.push_back(cyc);
      end
      if (req_valid) begin
        req_cnt++; req_cyc = cyc;
        if (req_head !== v.head || req_length !== v.len) head_bad++;
      end
      if (done_valid) begin
        done_cyc = cyc; got_count = done_count; got_to = done_timeout; got_busy = busy;
        break;
      end
    end
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    logic [4*CW-1:0] c;
    int j;
    string tag;
    c = v.csr;
    tag = $sformatf("v%0d", n);
    run_job(v, 0);
    check({tag, "_done_seen"}, done_cyc >= 0, 1);
    check({tag, "_wr_count"}, wr_addr.size(), $countones(v.wr_mask));
    j = 0;
    for (int a = 0; a < 4; a++) begin
      if (v.wr_mask[a] && j < wr_addr.size()) begin
        check({tag, "_wr_addr"}, wr_addr[j], a);
        check({tag, "_wr_data"}, wr_data[j], c[a*CW +: CW]);
        check({tag, "_wr_cycle"}, wr_cyc[j] - acc_cyc, 1 + j);
        j++;
      end
    end
    check({tag, "_req_pulses"}, req_cnt, 1);
    check({tag, "_req_latency"}, req_cyc - acc_cyc, v.req_lat);
    check({tag, "_req_fields_bad"}, head_bad, 0);
    check({tag, "_done_latency"}, done_cyc - req_cyc, v.done_lat);
    check({tag, "_done_count"}, got_count, v.exp_count);
    check({tag, "_done_timeout"}, got_to, v.exp_to);
    check({tag, "_encoding_bad"}, enc_bad, 0);
    check({tag, "_busy_at_done"}, got_busy, 1);
    @(posedge clock); #1;
    job_valid = 1'b0; hw_resp_valid = 1'b0; hw_req_ready = 1'b1;
    @(negedge clock);
    check({tag, "_ready_after"}, job_ready, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  vec_t vecs[5];
  vec_t vr, vp;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd0, 32'd1000, mk_csr(0, 1024, 1536, 0), 523, 1'b0, 1'b0, 1'b0,
                4'hF, 15, 525, 32'd523, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'd32, 32'd1000, mk_csr(256, 1024, 1536, 0), 1000, 1'b0, 1'b1, 1'b1,
                CACHE ? 4'h1 : 4'hF, CACHE ? 12 : 15, 1001, 32'd1000, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'd7, 32'd99, mk_csr(5, 6, 7, 8), 5, 1'b1, 1'b0, 1'b0,
                4'hF, 5, 51, 32'd5, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'd9, 32'd50, mk_csr(5, 6, 7, 8), 50, 1'b0, 1'b1, 1'b0,
                CACHE ? 4'h0 : 4'hF, CACHE ? 1 : 5, 51, 32'd50, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'd3, mk_csr(2047, 0, 2047, 1), 2, 1'b0, 1'b0, 1'b0,
                4'hF, 5, 4, 32'd2, 1'b0};
    vr = '{1'b0, 1'b1, 32'd77, 32'd88, mk_csr(1, 2, 3, 4), 20, 1'b1, 1'b0, 1'b0,
           4'hF, 15, 0, 32'd0, 1'b0};
    vp = '{1'b0, 1'b1, 32'd5, 32'd6, mk_csr(1, 2, 3, 4), 3, 1'b0, 1'b0, 1'b0,
           4'hF, 15, 5, 32'd3, 1'b0};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_job_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_csr_write", csr_write, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_count", done_count, 0);
    check("rst_done_timeout", done_timeout, 0);
    check("rst_encoding", encoding, 0);
    check("rst_b_job_ready", b_job_ready, 1);

    for (int n = 0; n < 5; n++) apply_vec(vecs[n], n);

    // Reset in RUN: abandon the job with no completion pulse.
    run_job(vr, 10);
    @(posedge clock); #1;
    reset = 1'b0; job_valid = 1'b0; hw_resp_valid = 1'b0; hw_req_ready = 1'b1;
    @(negedge clock);
    check("abort_no_done", done_cyc, -1);
    check("abort_job_ready", job_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done_valid", done_valid, 0);
    check("abort_encoding", encoding, 0);
    check("abort_done_count", done_count, 0);
    check("abort_req_head", req_head, 0);
    check("abort_state", a_state, IDLE);
    apply_vec(vp, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
